// File: rtl/sample_streamer.sv
// sample_streamer: plays a loaded sample table out one sample every DIV clocks with ready/strobe/done handshakes.
module sample_streamer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9,
    parameter int DIV    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] sample_out,
    output logic              ready,
    output logic              sample_stb,
    output logic              busy,
    output logic              done
);
    localparam int DW = $clog2(DIV);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DW-1:0] div_cnt;
    logic [ADDR_W-1:0] idx, len_r;
    logic loop_r, wrap, last, legal, halt;
    assign busy = state != IDLE;
    always_comb begin
        wrap = div_cnt == DW'(DIV - 1);
        last = idx == len_r - ADDR_W'(1);
        legal = len != '0 && 32'(len) <= DEPTH;
        halt = stop && busy;
        state_n = halt ? IDLE
                : state == IDLE ? (start && !stop && legal ? RUN : IDLE)
                : state == RUN ? (wrap && last && !loop_r ? DRAIN : RUN)
                : (wrap ? IDLE : DRAIN);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst_n && !busy && wr_en && 32'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= '0;
            len_r      <= '0;
            loop_r     <= 1'b0;
            sample_out <= '0;
            ready      <= 1'b0;
            sample_stb <= 1'b0;
            done       <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            done       <= 1'b0;
            div_cnt    <= wrap ? '0 : div_cnt + DW'(1);
            if (halt) begin
                sample_out <= '0;
                ready      <= 1'b0;
                done       <= 1'b1;
            end else if (state == IDLE) begin
                div_cnt <= '0;
                if (start && !stop) begin
                    len_r  <= len;
                    loop_r <= loop;
                    idx    <= '0;
                    done   <= !legal;
                end
            end else if (wrap) begin
                // RUN issues the next entry; DRAIN's wrap is the end of the hold period
                if (state == RUN) begin
                    sample_out <= mem[idx];
                    ready      <= 1'b1;
                    sample_stb <= 1'b1;
                    idx        <= last ? '0 : idx + ADDR_W'(1);
                end else begin
                    sample_out <= '0;
                    ready      <= 1'b0;
                    done       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed/randomized playback checks against a timeline model of the streamer.
module tb_sample_streamer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 400;
    localparam int ADDR_W = 9;
    localparam int DIV    = 20;
    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, loop = 1'b0, start = 1'b0, stop = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] sample_out;
    logic ready, sample_stb, busy, done;
    logic [DATA_W-1:0] tbl [DEPTH];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sample_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .loop(loop), .start(start), .stop(stop), .sample_out(sample_out),
        .ready(ready), .sample_stb(sample_stb), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [DATA_W-1:0] s, input bit r, input bit st,
                        input bit b, input bit d);
        chk({tag, ".sample"}, 32'(sample_out), 32'(s));
        chk({tag, ".ready"}, 32'(ready), 32'(r));
        chk({tag, ".stb"}, 32'(sample_stb), 32'(st));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        wr_addr = ADDR_W'(a);
        wr_data = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        if (a < DEPTH) tbl[a] = d;
    endtask

    // Expected outputs at cycle t after the start edge follow from the playback timeline:
    // sample k (k>=1) lands at k*DIV, playback ends at DIV*(L+1) or at the stop edge.
    task automatic play(input string tag, input int L, input bit lp, input int ncyc,
                        input int stop_t, input int wr_t, input int st_t);
        int end_t, fin;
        bit act, e_rdy;
        logic [DATA_W-1:0] e_smp;
        end_t = lp ? ncyc + 1000 : DIV * (L + 1);
        fin = (stop_t != 0 && stop_t < end_t) ? stop_t : end_t;
        len = ADDR_W'(L);
        loop = lp;
        start = 1'b1;
        step();
        start = 1'b0;
        outs($sformatf("%s@0", tag), '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int t = 1; t <= ncyc; t++) begin
            stop = (t == stop_t);
            wr_en = (t == wr_t);
            wr_addr = ADDR_W'(1);
            wr_data = DATA_W'($urandom);
            start = (t == st_t);
            len = ADDR_W'(2);
            step();
            stop = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
            act = t < fin;
            e_rdy = act && t >= DIV;
            e_smp = e_rdy ? tbl[(t / DIV - 1) % L] : '0;
            outs($sformatf("%s@%0d", tag, t), e_smp, e_rdy, act && (t % DIV == 0), act, t == fin);
        end
    endtask

    initial begin
        step();
        step();
        outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        wr_addr = ADDR_W'(5);
        wr_data = 8'h55;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        rst_n = 1'b1;
        step();

        wr(0, 8'd10);
        wr(1, 8'hFD);
        wr(2, 8'd7);
        wr(3, 8'd127);
        play("basic", 4, 1'b0, DIV * 5 + 3, 0, 0, 0);

        for (int i = 0; i < 8; i++) wr(i, DATA_W'($urandom));
        play("loop", 3, 1'b1, 7 * DIV + 10, 7 * DIV + 5, 0, 0);
        play("stop_drain", 2, 1'b0, 4 * DIV, 2 * DIV + 5, 0, 0);
        play("stop_run", 5, 1'b0, 7 * DIV, int'($urandom_range(DIV + 1, 5 * DIV - 1)), 0, 0);
        play("collide", 4, 1'b0, DIV * 5 + 3, 0, DIV + 10, 2 * DIV + 10);

        len = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        outs("len0", '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        outs("len0+1", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        len = ADDR_W'(DEPTH + 1);
        start = 1'b1;
        step();
        start = 1'b0;
        outs("lenbig", '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= DIV + 2; t++) begin
            step();
            outs($sformatf("lenbig@%0d", t), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        len = ADDR_W'(3);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        for (int t = 0; t <= DIV + 2; t++) begin
            outs($sformatf("startstop@%0d", t), '0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        play("prerst", 4, 1'b1, DIV + 15, 0, 0, 0);
        rst_n = 1'b0;
        step();
        outs("midrst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        play("replay", 4, 1'b0, DIV * 5 + 3, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
